display_scan_ctrl: RTL and testbench

//  Scan sequencer for the 4-digit 7-segment display mux: divides clk, drives the 2-bit digit select (scan),
//  and inserts an inter-digit blanking window against ghosting. Holds double-buffered display registers
//  (hexs/point/les/blink) loaded through a valid/ready port and committed only at frame boundaries.

---
 rtl/display_scan_ctrl_pkg.sv | 28 ++
 rtl/display_scan_ctrl_scan_prescaler.sv | 41 ++++
 rtl/display_scan_ctrl.sv | 107 ++++++++++
 tb/tb_display_scan_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan sequencer.
// Provides the digit count, the scan select width, default timing
// parameters, and the display-word layout used by both the shadow
// and the committed display registers.
package display_scan_ctrl_pkg;

  localparam int unsigned DIGITS           = 4;
  localparam int unsigned SCAN_W           = 2;
  localparam int unsigned DEF_SCAN_DIV     = 100000;
  localparam int unsigned DEF_BLANK_CYC    = 1000;
  localparam int unsigned DEF_BLINK_FRAMES = 64;

  // One complete set of display contents (28 bits).
  typedef struct packed {
    logic [15:0] hexs;   // four hex digits, [3:0] = digit 0
    logic [3:0]  point;  // decimal point per digit
    logic [3:0]  les;    // latch enable per digit
    logic [3:0]  blink;  // blink enable per digit
  } disp_word_t;

  localparam disp_word_t DISP_RESET = '{
    hexs:  16'h0000,
    point: 4'hF,
    les:   4'h0,
    blink: 4'h0
  };

endpackage

// File: rtl/display_scan_ctrl_scan_prescaler.sv
// Digit-slot prescaler for the display scan sequencer.
// Counts clk cycles within one digit slot and flags the last cycle of
// the slot and the blanking window at the start of the slot.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   tick out 1 on the last cycle of a slot (cnt == SCAN_DIV-1)
//   win  out 1 while cnt < BLANK_CYC
module scan_prescaler
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = DEF_SCAN_DIV,
  parameter int unsigned BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic win
);

  localparam int unsigned     CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic             HAS_BLANK = (BLANK_CYC != 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);
  assign win  = HAS_BLANK & (cnt < CNT_BLANK);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan sequencer for the 4-digit 7-segment display mux.
// Steps the digit select once per slot, blanks the anodes at the start of
// every slot and for blinking digits, and double-buffers the display
// contents so a new word only takes effect at a frame boundary.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   upd_valid    in  new display word offered
//   upd_ready    out shadow buffer free (transfer on valid & ready)
//   hexs_in, point_in, les_in, blink_in   in  offered display word
//   scan         out digit select
//   hexs_q, point_q, les_q                out committed display word
//   blank        out 1 = force all anodes off
//   frame_start  out 1-cycle pulse on the first cycle of each frame
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV,
  parameter int unsigned BLANK_CYC    = DEF_BLANK_CYC,
  parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [15:0]       hexs_in,
  input  logic [3:0]        point_in,
  input  logic [3:0]        les_in,
  input  logic [3:0]        blink_in,
  output logic [SCAN_W-1:0] scan,
  output logic [15:0]       hexs_q,
  output logic [3:0]        point_q,
  output logic [3:0]        les_q,
  output logic              blank,
  output logic              frame_start
);

  localparam int unsigned    FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic        tick;
  logic        win;
  logic        frame_end;
  logic        xfer;
  logic        pending;
  logic        blink_phase;
  logic [FC_W-1:0] frame_cnt;
  disp_word_t  shadow;
  disp_word_t  disp_q;

  scan_prescaler #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .win  (win)
  );

  assign frame_end = tick & (scan == SCAN_W'(DIGITS - 1));
  assign upd_ready = ~pending;
  assign xfer      = upd_valid & ~pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan        <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (tick) begin
        scan <= scan + 1'b1;
      end
      if (frame_end) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Transfer needs pending=0 and commit needs pending=1, so the two never
  // coincide: a word accepted in a frame_end cycle waits for the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      pending <= 1'b0;
      disp_q  <= DISP_RESET;
    end else if (xfer) begin
      shadow  <= '{hexs: hexs_in, point: point_in, les: les_in, blink: blink_in};
      pending <= 1'b1;
    end else if (frame_end && pending) begin
      disp_q  <= shadow;
      pending <= 1'b0;
    end
  end

  assign blank   = win | (blink_phase & disp_q.blink[scan]);
  assign hexs_q  = disp_q.hexs;
  assign point_q = disp_q.point;
  assign les_q   = disp_q.les;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] hexs_in = '0;
  logic [3:0]  point_in = '0;
  logic [3:0]  les_in = '0;
  logic [3:0]  blink_in = '0;
  logic [1:0]  scan;
  logic [15:0] hexs_q;
  logic [3:0]  point_q;
  logic [3:0]  les_q;
  logic        blank;
  logic        frame_start;

  typedef struct {
    logic [15:0] hexs;
    logic [3:0]  point;
    logic [3:0]  les;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   k = 0;  // clock edges since reset release

  display_scan_ctrl #(
    .SCAN_DIV     (8),
    .BLANK_CYC    (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .hexs_in     (hexs_in),
    .point_in    (point_in),
    .les_in      (les_in),
    .blink_in    (blink_in),
    .scan        (scan),
    .hexs_q      (hexs_q),
    .point_q     (point_q),
    .les_q       (les_q),
    .blank       (blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", name, k, act, exp);
  endtask

  // Return #1 after clock edge n (counted from reset release).
  task automatic at(input int n);
    while (k < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l,
                       input logic [3:0] b);
    hexs_in   = h;
    point_in  = p;
    les_in    = l;
    blink_in  = b;
    upd_valid = 1'b1;
  endtask

  task automatic push(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    exp_t e;
    e.hexs  = h;
    e.point = p;
    e.les   = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every frame_start presents a frame; compare with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && frame_start) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL frame_unexpected at edge %0d: got hexs %0h expected no frame", k, hexs_q);
        end else begin
          e = exp_q.pop_front();
          chk("frame_hexs", hexs_q, e.hexs);
          chk("frame_point", point_q, e.point);
          chk("frame_les", les_q, e.les);
          chk("frame_scan", scan, 0);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "timeout");
  end

  initial begin
    push(16'h0000, 4'hF, 4'h0);          // frame at edge 32
    #22;
    rst = 1'b0;
    // 1: reset state and idle scanning
    chk("rst_scan", scan, 0);
    chk("rst_hexs", hexs_q, 16'h0000);
    chk("rst_point", point_q, 4'hF);
    chk("rst_les", les_q, 4'h0);
    chk("rst_ready", upd_ready, 1);
    chk("rst_blank", blank, 1);
    chk("rst_fs", frame_start, 0);
    for (int n = 1; n <= 40; n++) begin
      at(n);
      chk("idle_scan", scan, (n / 8) % 4);
      chk("idle_blank", blank, ((n % 8) < 2) ? 1 : 0);
      chk("idle_fs", frame_start, (n == 32) ? 1 : 0);
    end

    // 2: mid-frame update, committed at the frame boundary
    offer(16'h1234, 4'h5, 4'hA, 4'h0);
    push(16'h1234, 4'h5, 4'hA);          // frame at edge 64
    at(41);
    chk("t2_ready_low", upd_ready, 0);
    upd_valid = 1'b0;

    // 3: second word held while pending, accepted at commit
    at(50);
    offer(16'hABCD, 4'h0, 4'hF, 4'h0);
    push(16'hABCD, 4'h0, 4'hF);          // frame at edge 96
    at(55);
    chk("t3_ready_held", upd_ready, 0);
    chk("t3_hexs_old", hexs_q, 16'h0000);
    at(63);
    chk("t2_hexs_before", hexs_q, 16'h0000);
    at(64);
    chk("t3_ready_commit", upd_ready, 1);
    chk("t2_hexs_commit", hexs_q, 16'h1234);
    at(65);
    chk("t3_accepted", upd_ready, 0);
    upd_valid = 1'b0;
    at(95);
    chk("t3_hexs_wait", hexs_q, 16'h1234);

    // 4: blink on digit 2
    at(100);
    offer(16'h5678, 4'h3, 4'hC, 4'b0100);
    for (int f = 0; f < 6; f++) push(16'h5678, 4'h3, 4'hC);  // edges 128..288
    at(101);
    upd_valid = 1'b0;
    at(148);
    chk("t4_d2_visible", blank, 0);
    at(204);
    chk("t4_d1_unaffected", blank, 0);
    at(212);
    chk("t4_d2_blanked", blank, 1);
    at(215);
    chk("t4_d2_blanked_end", blank, 1);
    at(276);
    chk("t4_d2_visible_again", blank, 0);

    // 5: transfer exactly in the frame_end cycle
    at(287);
    chk("t5_scan_last", scan, 3);
    offer(16'h9ABC, 4'h9, 4'h6, 4'b0001);
    push(16'h9ABC, 4'h9, 4'h6);          // frame at edge 320
    at(288);
    chk("t5_ready_low", upd_ready, 0);
    upd_valid = 1'b0;
    at(300);
    chk("t5_hexs_unchanged", hexs_q, 16'h5678);
    at(324);
    chk("t5_d0_blink", blank, 1);
    at(332);
    chk("t5_d1_visible", blank, 0);

    // 6: reset mid-slot with an update pending
    at(333);
    offer(16'hDEAD, 4'h1, 4'h1, 4'h0);
    at(334);
    upd_valid = 1'b0;
    chk("t6_pending", upd_ready, 0);
    at(337);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_scan", scan, 0);
    chk("t6_hexs", hexs_q, 16'h0000);
    chk("t6_point", point_q, 4'hF);
    chk("t6_les", les_q, 4'h0);
    chk("t6_ready", upd_ready, 1);
    chk("t6_blank", blank, 1);
    chk("t6_fs", frame_start, 0);
    chk("t6_queue_before", exp_q.size(), 0);
    push(16'h0000, 4'hF, 4'h0);
    push(16'h0000, 4'hF, 4'h0);
    #3;
    rst = 1'b0;
    at(1);
    chk("t6_restart_scan", scan, 0);
    at(70);
    chk("t6_no_old_shadow", hexs_q, 16'h0000);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
